// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: FSM state encodings
// and default payload width.
package pipe_pkg;

  localparam int DATA_W_DEF = 96;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating 32-bit event counter clocked on the falling edge of Clk,
// used by pipe_stage_reg when PIPE_STAGE_PERF_EN is defined.
module pipe_perf_cnt (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(negedge Clk or negedge Clrn) begin
    if (!Clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage, state updates on negedge Clk.
// Optional stall/flush counters are enabled with macro PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, rel;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign rel       = out_valid & out_ready & ~stall;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && rel) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (rel) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        TWO: begin
          // in_ready is low here, so only a release can move the state
          if (rel) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(negedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .inc_i (stall & out_valid),
    .cnt_o (stall_cnt)
  );

  pipe_perf_cnt u_flush_cnt (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .inc_i (flush),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, payload width (e.g. PC4+PC+Inst).
REQ-002 SHALL have parameter BUBBLE, default {DATA_W{1'b0}}, payload value driven when no valid entry is held.
REQ-003 Clk  input  1  clock; all state updates on the negative edge.
REQ-004 Clrn  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  discard all held and incoming entries (branch/jump taken).
REQ-006 stall  input  1  hold the output entry; acts as out_ready forced low.
REQ-007 in_valid  input  1  upstream entry valid.
REQ-008 in_ready  output  1  stage can accept an entry; registered.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  output entry valid.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_data  output  DATA_W  output payload.
REQ-013 occupancy  output  2  held entries (0..2).

Function
REQ-014 SHALL hold a 2-entry buffer: main slot (drives out_*) and skid slot.
REQ-015 FSM states EMPTY, ONE, TWO; occupancy equals 0, 1, 2 respectively.
REQ-016 Accept = in_valid & in_ready; Release = out_valid & out_ready & ~stall.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO.
REQ-018 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-019 EMPTY + Accept -> ONE, main <= in_data; latency one Clk negedge.
REQ-020 ONE + Accept + Release -> ONE, main <= in_data.
REQ-021 ONE + Accept, no Release -> TWO, skid <= in_data.
REQ-022 ONE + Release, no Accept -> EMPTY, main <= BUBBLE.
REQ-023 TWO + Release -> ONE, main <= skid, skid <= BUBBLE.
REQ-024 No Accept and no Release SHALL leave state and both slots unchanged.
REQ-025 flush=1 SHALL have priority over all other inputs: next state EMPTY, both slots <= BUBBLE, and any same-edge Accept is discarded.
REQ-026 out_data SHALL equal BUBBLE whenever out_valid=0.
REQ-027 Entries SHALL leave in acceptance order; none dropped or duplicated except by flush.
REQ-028 stall=1 with flush=1 SHALL flush.

Reset
REQ-029 Clrn=0 SHALL immediately force state EMPTY, slots BUBBLE, in_ready=1, out_valid=0, occupancy=0, and counters 0, regardless of Clk.
REQ-030 After release, first Accept SHALL occur at the first negedge with in_valid=1.

Configuration
REQ-031 Macro PIPE_STAGE_PERF_EN SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-032 stall_cnt SHALL increment at each negedge with stall=1 and out_valid=1. flush_cnt SHALL increment at each negedge with flush=1. Both SHALL saturate at 32'hFFFFFFFF.
REQ-033 Without PIPE_STAGE_PERF_EN, these ports and counters SHALL not exist. All other behaviour SHALL be identical.

Structure
REQ-035 Shared package pipe_pkg SHALL hold the FSM state encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default DATA_W value.
REQ-036 Counters SHALL live in one sub-module, pipe_perf_cnt, instanced twice, and only under PIPE_STAGE_PERF_EN.

Verification
REQ-037 Stream: in_data 1..8 each cycle, out_ready=1 -> out_data 1..8 one negedge later, occupancy stays 1.
REQ-038 Backpressure: out_ready=0 while sending A, B, C -> occupancy 1 then 2, in_ready=0 after B, C held upstream. Then out_ready=1 -> A, B, C delivered in order.
REQ-039 Flush in TWO with in_valid=1 (D) -> next negedge occupancy=0, out_valid=0, out_data=0, D never appears.
REQ-040 stall=1 in ONE with out_ready=1 for 3 cycles -> out_data held, no Release. With PIPE_STAGE_PERF_EN, stall_cnt=3.
REQ-041 Clrn pulsed low mid-cycle in TWO -> outputs cleared before next edge, in_ready=1.
REQ-042 Simultaneous Accept and Release in ONE for 100 random cycles -> scoreboard matches, occupancy never reaches 2.
